// File: rtl/resource_lock_scheduler.sv
// rtl/resource_lock_scheduler.sv - age-ordered lock scheduler sharing NUM_UNITS units among NUM_PORTS requesters
// Optional hold-time watchdog: define RESOURCE_LOCK_HOLD_TIMEOUT_EN.
module resource_lock_scheduler #(
  parameter int NUM_PORTS = 8,
  parameter int NUM_UNITS = 8,
  parameter int ID_WIDTH = 16,
  parameter int MAX_HOLD_CYCLES = 64,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CW = $clog2(NUM_UNITS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
  input  logic [NUM_PORTS-1:0]          release_pulse,
  input  logic                          flush,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS*UW-1:0]       grant_unit,
  output logic [NUM_UNITS-1:0]          unit_busy,
  output logic [NUM_UNITS*PW-1:0]       unit_owner,
  output logic [CW-1:0]                 busy_count,
  output logic                          timeout_err
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t               state_q     [NUM_PORTS];
  state_t               state_d     [NUM_PORTS];
  logic [UW-1:0]        port_unit_q [NUM_PORTS];
  logic [UW-1:0]        port_unit_d [NUM_PORTS];
  logic [PW-1:0]        owner_q     [NUM_UNITS];
  logic [PW-1:0]        owner_d     [NUM_UNITS];
  logic [NUM_UNITS-1:0] busy_q, busy_d;
  logic [CW-1:0]        count_q;
  logic [NUM_UNITS-1:0] expire;
  logic [NUM_PORTS-1:0] cand;
  int                   rank        [NUM_PORTS];
  int                   free_idx    [NUM_UNITS];

  if (MAX_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("MAX_HOLD_CYCLES must be at least 1");
  end

  // Wrap-aware age: a is older when (a - b) has its MSB set; ties favour the lower port.
  function automatic logic older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b,
                                 input logic a_lower);
    logic [ID_WIDTH-1:0] diff;
    diff = a - b;
    if (diff == '0) return a_lower;
    return diff[ID_WIDTH-1];
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      cand[p] = req_valid[p] && (state_q[p] == IDLE) && !release_pulse[p] && !flush;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rank[p] = 0;
      for (int q = 0; q < NUM_PORTS; q++)
        if (q != p && cand[q] && older(req_id[q*ID_WIDTH +: ID_WIDTH],
                                       req_id[p*ID_WIDTH +: ID_WIDTH], q < p))
          rank[p] = rank[p] + 1;
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      free_idx[u] = 0;
      for (int v = 0; v < u; v++)
        if (!busy_q[v]) free_idx[u] = free_idx[u] + 1;
    end
  end

  // Next state: releases and expiries free units for the following cycle only;
  // allocation sees just the units that were free at the start of this cycle.
  always_comb begin
    logic taken;
    taken       = 1'b0;
    state_d     = state_q;
    port_unit_d = port_unit_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    if (flush) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_d[p]     = IDLE;
        port_unit_d[p] = '0;
      end
      for (int u = 0; u < NUM_UNITS; u++) owner_d[u] = '0;
      busy_d = '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (state_q[p] == GRANTED && release_pulse[p]) begin
          state_d[p]                  = IDLE;
          port_unit_d[p]              = '0;
          busy_d[port_unit_q[p]]      = 1'b0;
          owner_d[port_unit_q[p]]     = '0;
        end
      for (int u = 0; u < NUM_UNITS; u++)
        if (expire[u]) begin
          busy_d[u]                   = 1'b0;
          owner_d[u]                  = '0;
          state_d[owner_q[u]]         = IDLE;
          port_unit_d[owner_q[u]]     = '0;
        end
      for (int u = 0; u < NUM_UNITS; u++)
        if (!busy_q[u]) begin
          taken = 1'b0;
          for (int p = 0; p < NUM_PORTS; p++)
            if (!taken && cand[p] && rank[p] == free_idx[u]) begin
              taken          = 1'b1;
              state_d[p]     = GRANTED;
              port_unit_d[p] = UW'(u);
              busy_d[u]      = 1'b1;
              owner_d[u]     = PW'(p);
            end
        end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p]     <= IDLE;
        port_unit_q[p] <= '0;
      end
      for (int u = 0; u < NUM_UNITS; u++) owner_q[u] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      state_q     <= state_d;
      port_unit_q <= port_unit_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      count_q     <= CW'($countones(busy_d));
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      grant[p]               = (state_q[p] == GRANTED);
      grant_unit[p*UW +: UW] = port_unit_q[p];
    end
    for (int u = 0; u < NUM_UNITS; u++) unit_owner[u*PW +: PW] = owner_q[u];
    unit_busy  = busy_q;
    busy_count = count_q;
  end

`ifdef RESOURCE_LOCK_HOLD_TIMEOUT_EN
  localparam int HW = (MAX_HOLD_CYCLES > 1) ? $clog2(MAX_HOLD_CYCLES) : 1;
  logic [HW-1:0] hold_q [NUM_UNITS];
  logic          terr_q;

  always_comb
    for (int u = 0; u < NUM_UNITS; u++)
      expire[u] = !flush && busy_q[u] && (hold_q[u] == HW'(MAX_HOLD_CYCLES - 1)) &&
                  !release_pulse[owner_q[u]];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int u = 0; u < NUM_UNITS; u++) hold_q[u] <= '0;
      terr_q <= 1'b0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++)
        hold_q[u] <= (busy_q[u] && busy_d[u]) ? hold_q[u] + 1'b1 : '0;
      terr_q <= terr_q | (|expire);
    end
  end

  assign timeout_err = terr_q;
`else
  assign expire      = '0;
  assign timeout_err = 1'b0;
`endif

  logic inv_ok;
  always_comb begin
    int n;
    n      = 0;
    inv_ok = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      n = 0;
      for (int u = 0; u < NUM_UNITS; u++)
        if (busy_q[u] && owner_q[u] == PW'(p)) n = n + 1;
      if (n != ((state_q[p] == GRANTED) ? 1 : 0)) inv_ok = 1'b0;
      if (state_q[p] == GRANTED &&
          (!busy_q[port_unit_q[p]] || owner_q[port_unit_q[p]] != PW'(p)))
        inv_ok = 1'b0;
    end
  end

  always_ff @(posedge clk)
    if (!reset) assert (inv_ok);

endmodule

// File: tb/tb_resource_lock_scheduler.sv
// tb/tb_resource_lock_scheduler.sv - directed and randomized bench for resource_lock_scheduler
module tb_resource_lock_scheduler;
  localparam int NP = 8, NU = 4, IDW = 16, MH = 32;
  localparam int UW = 2, PW = 3, CW = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NP-1:0]       req_valid, rel;
  logic [NP*IDW-1:0]   req_id;
  logic                flush;
  logic [NP-1:0]       grant;
  logic [NP*UW-1:0]    grant_unit;
  logic [NU-1:0]       unit_busy;
  logic [NU*PW-1:0]    unit_owner;
  logic [CW-1:0]       busy_count;
  logic                timeout_err;

  always #5 clk = ~clk;

  resource_lock_scheduler #(.NUM_PORTS(NP), .NUM_UNITS(NU), .ID_WIDTH(IDW), .MAX_HOLD_CYCLES(MH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id), .release_pulse(rel),
    .flush(flush), .grant(grant), .grant_unit(grant_unit), .unit_busy(unit_busy),
    .unit_owner(unit_owner), .busy_count(busy_count), .timeout_err(timeout_err));

  // Reference model: which unit each port holds, who holds each unit, and hold ages.
  int m_unit_of [NP];
  int m_owner   [NU];
  int m_age     [NU];
  bit m_terr;
  int n_total = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic int id_of(input int p);
    return int'(req_id[p*IDW +: IDW]);
  endfunction

  // Signed distance a-b on the ID circle; negative means a is older.
  function automatic int sdiff(input int a, input int b);
    int d;
    d = a - b;
    if (d >= (1 << (IDW-1))) d -= (1 << IDW);
    else if (d < -(1 << (IDW-1))) d += (1 << IDW);
    return d;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_unit_of[p] = -1;
    for (int u = 0; u < NU; u++) begin m_owner[u] = -1; m_age[u] = 0; end
    m_terr = 1'b0;
  endtask

  task automatic model_step();
    int free_q[$];
    int order[$];
    int key[NP];
    bit exp_u[NU];
    int ref_p, i, p, u;
    if (flush) begin
      for (int k = 0; k < NP; k++) m_unit_of[k] = -1;
      for (int k = 0; k < NU; k++) begin m_owner[k] = -1; m_age[k] = 0; end
      return;
    end
    for (int k = 0; k < NU; k++) if (m_owner[k] < 0) free_q.push_back(k);
    ref_p = -1;
    for (int k = 0; k < NP; k++)
      if (req_valid[k] && !rel[k] && m_unit_of[k] < 0) begin
        if (ref_p < 0) ref_p = k;
        key[k] = sdiff(id_of(k), id_of(ref_p)) * NP + k;
        i = 0;
        while (i < order.size() && key[order[i]] < key[k]) i++;
        order.insert(i, k);
      end
    for (int k = 0; k < NU; k++) exp_u[k] = 1'b0;
`ifdef RESOURCE_LOCK_HOLD_TIMEOUT_EN
    for (int k = 0; k < NU; k++)
      exp_u[k] = (m_owner[k] >= 0) && (m_age[k] == MH - 1) && !rel[m_owner[k]];
`endif
    for (int k = 0; k < NP; k++)
      if (rel[k] && m_unit_of[k] >= 0) begin
        m_owner[m_unit_of[k]] = -1;
        m_unit_of[k] = -1;
      end
    for (int k = 0; k < NU; k++)
      if (exp_u[k]) begin
        m_unit_of[m_owner[k]] = -1;
        m_owner[k] = -1;
        m_terr = 1'b1;
      end
    for (int k = 0; k < NU; k++) if (m_owner[k] >= 0) m_age[k]++;
    for (int k = 0; k < order.size() && k < free_q.size(); k++) begin
      p = order[k];
      u = free_q[k];
      m_owner[u] = p;
      m_unit_of[p] = u;
      m_age[u] = 0;
    end
  endtask

  task automatic check_all();
    logic [NP-1:0]    eg;
    logic [NP*UW-1:0] egu;
    logic [NU-1:0]    eb;
    logic [NU*PW-1:0] eo;
    int cnt;
    eg = '0; egu = '0; eb = '0; eo = '0; cnt = 0;
    for (int p = 0; p < NP; p++)
      if (m_unit_of[p] >= 0) begin
        eg[p] = 1'b1;
        egu[p*UW +: UW] = UW'(m_unit_of[p]);
      end
    for (int u = 0; u < NU; u++)
      if (m_owner[u] >= 0) begin
        eb[u] = 1'b1;
        eo[u*PW +: PW] = PW'(m_owner[u]);
        cnt++;
      end
    chk("grant", grant, eg);
    chk("grant_unit", grant_unit, egu);
    chk("unit_busy", unit_busy, eb);
    chk("unit_owner", unit_owner, eo);
    chk("busy_count", busy_count, cnt);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  task automatic cycle();
    if (reset) model_reset(); else model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input int p, input logic [IDW-1:0] id);
    req_valid[p] = 1'b1;
    req_id[p*IDW +: IDW] = id;
  endtask

  logic [IDW-1:0] base;

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = '0; rel = '0; req_id = '0;
    model_reset();
    @(negedge clk);
    cycle();
    chk("reset_grant", grant, 0);
    chk("reset_busy", unit_busy, 0);
    reset = 1'b0;

    // Age ordering: two units pre-held, IDs 5,3,9 compete for units 2 and 3.
    set_req(6, 100); set_req(7, 101); cycle();
    req_valid[6] = 1'b0; req_valid[7] = 1'b0;
    set_req(0, 5); set_req(1, 3); set_req(2, 9); cycle();
    chk("a_grant", grant[2:0], 3'b011);
    chk("a_p1_unit", grant_unit[1*UW +: UW], 2);
    chk("a_p0_unit", grant_unit[0 +: UW], 3);
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    cycle();
    chk("a_p2_wait", grant[2], 0);
    rel[1] = 1'b1; cycle(); rel[1] = 1'b0;
    chk("a_p2_not_same_edge", grant[2], 0);
    cycle();
    chk("a_p2_granted", grant[2], 1);
    chk("a_p2_unit", grant_unit[2*UW +: UW], 2);
    req_valid[2] = 1'b0;

    // Release and request in the same cycle with the pool full.
    rel[0] = 1'b1; set_req(4, 50); cycle(); rel[0] = 1'b0;
    chk("c_p4_wait", grant[4], 0);
    cycle();
    chk("c_p4_granted", grant[4], 1);
    chk("c_p4_unit", grant_unit[4*UW +: UW], 3);
    chk("c_count_full", busy_count, NU);
    req_valid[4] = 1'b0;

    // Wrap-around compare with one free unit.
    rel[2] = 1'b1; cycle(); rel[2] = 1'b0;
    set_req(0, 16'hFFFE); set_req(1, 16'h0001); cycle();
    chk("b_wrap_grant", grant[1:0], 2'b01);
    req_valid[0] = 1'b0;
    rel[0] = 1'b1; cycle(); rel[0] = 1'b0;
    chk("b_p1_wait", grant[1], 0);
    cycle();
    chk("b_p1_granted", grant[1], 1);
    req_valid[1] = 1'b0;

    // Full pool with four waiters; three simultaneous releases.
    set_req(0, 40); set_req(2, 10); set_req(3, 30); set_req(5, 20);
    cycle(); cycle();
    chk("d_no_grant", grant & 8'b0010_1101, 0);
    rel[6] = 1'b1; rel[7] = 1'b1; rel[4] = 1'b1; cycle(); rel = '0;
    cycle();
    chk("d_oldest_three", grant, 8'h2E);
    chk("d_p5_unit", grant_unit[5*UW +: UW], 1);
    req_valid[2] = 1'b0; req_valid[3] = 1'b0; req_valid[5] = 1'b0;

    // Flush with locks held and requests pending.
    set_req(7, 45);
    flush = 1'b1; cycle(); flush = 1'b0; req_valid = '0;
    chk("f_grant", grant, 0);
    chk("f_count", busy_count, 0);
    set_req(3, 77); cycle();
    chk("f_regrant_unit0", {grant[3], grant_unit[3*UW +: UW]}, 3'b100);
    req_valid[3] = 1'b0;

    // Hold limit: lock held without release.
    flush = 1'b1; cycle(); flush = 1'b0;
    set_req(0, 1); cycle(); req_valid[0] = 1'b0;
    for (int i = 0; i < MH - 1; i++) cycle();
    chk("t_grant_before_limit", grant[0], 1);
    cycle();
`ifdef RESOURCE_LOCK_HOLD_TIMEOUT_EN
    chk("t_forced_release", {grant[0], timeout_err}, 2'b01);
`else
    chk("t_no_watchdog", {grant[0], timeout_err}, 2'b10);
`endif
    flush = 1'b1; cycle(); flush = 1'b0;
`ifdef RESOURCE_LOCK_HOLD_TIMEOUT_EN
    chk("t_sticky_flush", timeout_err, 1);
`else
    chk("t_tied_zero", timeout_err, 0);
`endif

    // Randomized traffic against the model; IDs drift across the 16-bit wrap.
    base = 16'hFC00;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (m_unit_of[p] >= 0) begin
          rel[p] = ($urandom_range(0, 3) == 0);
          req_valid[p] = ($urandom_range(0, 7) == 0);
        end else begin
          rel[p] = ($urandom_range(0, 15) == 0);
          if (!req_valid[p]) begin
            if ($urandom_range(0, 2) == 0) set_req(p, base + IDW'($urandom_range(0, 2000)));
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid[p] = 1'b0;
          end
        end
      end
      flush = ($urandom_range(0, 99) == 0);
      reset = (c == 300);
      base = base + IDW'($urandom_range(0, 40));
      cycle();
    end
    reset = 1'b0; flush = 1'b0; rel = '0; req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
